// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// State encoding and counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; at least one bit even for WIDTH=1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Gate-level 1-bit full adder.
// The single arithmetic cell sequenced by serial_adder_ctrl.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_axb;
  logic w_ab;
  logic w_cx;

  assign w_axb  = i_a ^ i_b;
  assign w_ab   = i_a & i_b;
  assign w_cx   = w_axb & i_cin;
  assign o_sum  = w_axb ^ i_cin;
  assign o_cout = w_ab | w_cx;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one fa_cell over WIDTH cycles.
// Optional subtract mode via `define SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic w_acc;
  logic w_last;
  logic w_sub;
  logic w_abit;
  logic w_bbit;
  logic w_s;
  logic w_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_acc  = in_valid & in_ready;
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign sum    = r_sum;
  assign cout   = r_cout;

  // Select the operand bits addressed by the bit counter.
  always_comb begin
    w_abit = 1'b0;
    w_bbit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_abit = r_a[i];
        w_bbit = r_b[i];
      end
    end
  end

  fa_cell u_fa (
    .i_a    (w_abit),
    .i_b    (w_bbit),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and one bit of serial addition per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_acc) begin
      r_a     <= a;
      r_b     <= w_sub ? ~b : b;
      r_carry <= w_sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_cnt == CNT_W'(i)) r_sum[i] <= w_s;
      end
      r_carry <= w_c;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_cout <= w_c;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
// Subtract cases run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       out_valid, out_ready;
  logic [7:0] sum;
  logic       cout, busy;

  logic       w1_in_valid, w1_in_ready;
  logic [0:0] w1_a, w1_b;
  logic       w1_cin, w1_sub;
  logic       w1_out_valid, w1_out_ready;
  logic [0:0] w1_sum;
  logic       w1_cout, w1_busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .a         (w1_a),
    .b         (w1_b),
    .cin       (w1_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (w1_sub),
`endif
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .sum       (w1_sum),
    .cout      (w1_cout),
    .busy      (w1_busy)
  );

  // Drive one operation into dut8 and push its expected result.
  task automatic accept8(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic ts);
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b1;
    a   = ta;
    b   = tb;
    cin = tc;
    sub = ts;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sub = 1'b0;
    if (ts) q8.push_back({1'b0, ta} + {1'b0, ~tb} + 9'd1);
    else    q8.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
  endtask

  // Count edges from the accepting edge until out_valid (bounded).
  task automatic wait_out8(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_hs rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    else n_pass++;
    n_checks++;
    if ({cout, sum} !== 9'd0)
      $display("FAIL reset_res got %h want 000", {cout, sum});
    else n_pass++;
    n_checks++;
    if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0 ||
        {w1_cout, w1_sum} !== 2'b00)
      $display("FAIL reset_w1 rdy=%b ov=%b res=%b want 1 0 00",
               w1_in_ready, w1_out_valid, {w1_cout, w1_sum});
    else n_pass++;
  endtask

  task automatic test_add();
    logic [7:0] va[7];
    logic [7:0] vb[7];
    logic       vc[7];
    logic [8:0] exp;
    int lat;
    va = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00};
    vb = '{8'h3C, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 5; i < 7; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
      vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 7; i++) begin
      accept8(va[i], vb[i], vc[i], 1'b0);
      wait_out8(lat);
      exp = q8.pop_front();
      n_checks++;
      if (lat !== 8) $display("FAIL add_lat[%0d] got %0d want 8", i, lat);
      else n_pass++;
      n_checks++;
      if ({cout, sum} !== exp)
        $display("FAIL add_res[%0d] got %h want %h", i, {cout, sum}, exp);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL add_done[%0d] rdy=%b busy=%b want 0 1",
                 i, in_ready, busy);
      else n_pass++;
      release8();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cout, sum} !== exp)
        $display("FAIL add_idle[%0d] ov=%b rdy=%b res=%h want 0 1 %h",
                 i, out_valid, in_ready, {cout, sum}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp;
    int lat;
    accept8(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_out8(lat);
    exp = q8.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a = 8'hFF;
      b = 8'hFF;
      cin = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp)
        $display("FAIL bp_hold[%0d] ov=%b rdy=%b res=%h want 1 0 %h",
                 c, out_valid, in_ready, {cout, sum}, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release8();
    accept8(8'h12, 8'h34, 1'b1, 1'b0);
    wait_out8(lat);
    exp = q8.pop_front();
    n_checks++;
    if (lat !== 8 || {cout, sum} !== exp)
      $display("FAIL bp_next lat=%0d res=%h want 8 %h", lat, {cout, sum}, exp);
    else n_pass++;
    release8();
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept8(8'(8'h31 * (i + 1)), 8'(8'h47 + i), 1'(i), 1'b0);
      wait_out8(lat);
      exp = q8.pop_front();
      n_checks++;
      if (lat !== 8 || {cout, sum} !== exp || in_ready !== 1'b0)
        $display("FAIL b2b[%0d] lat=%0d res=%h rdy=%b want 8 %h 0",
                 i, lat, {cout, sum}, in_ready, exp);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL b2b_ret[%0d] ov=%b rdy=%b want 0 1",
                 i, out_valid, in_ready);
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    accept8(8'hC3, 8'h5F, 1'b1, 1'b0);
    void'(q8.pop_back());
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        {cout, sum} !== 9'd0)
      $display("FAIL rst_mid ov=%b rdy=%b busy=%b res=%h want 0 1 0 000",
               out_valid, in_ready, busy, {cout, sum});
    else n_pass++;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_stay ov=%b rdy=%b want 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      w1_in_valid = 1'b1;
      w1_a   = 1'(i >> 2);
      w1_b   = 1'(i >> 1);
      w1_cin = 1'(i);
      @(posedge clk); #1;
      w1_in_valid = 1'b0;
      q1.push_back({1'b0, w1_a} + {1'b0, w1_b} + {1'b0, w1_cin});
      @(posedge clk); #1;
      exp = q1.pop_front();
      n_checks++;
      if (w1_out_valid !== 1'b1 || {w1_cout, w1_sum} !== exp)
        $display("FAIL w1[%0d] ov=%b res=%b want 1 %b",
                 i, w1_out_valid, {w1_cout, w1_sum}, exp);
      else n_pass++;
      w1_out_ready = 1'b1;
      @(posedge clk); #1;
      w1_out_ready = 1'b0;
      n_checks++;
      if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0)
        $display("FAIL w1_ret[%0d] rdy=%b ov=%b want 1 0",
                 i, w1_in_ready, w1_out_valid);
      else n_pass++;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] va[3];
    logic [7:0] vb[3];
    logic [8:0] exp;
    int lat;
    va = '{8'h10, 8'h01, 8'h77};
    vb = '{8'h01, 8'h02, 8'h77};
    for (int i = 0; i < 3; i++) begin
      accept8(va[i], vb[i], 1'b0, 1'b1);
      wait_out8(lat);
      exp = q8.pop_front();
      n_checks++;
      if (lat !== 8 || {cout, sum} !== exp)
        $display("FAIL sub[%0d] lat=%0d res=%h want 8 %h",
                 i, lat, {cout, sum}, exp);
      else n_pass++;
      release8();
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b0;
    w1_in_valid = 1'b0;
    w1_a = '0;
    w1_b = '0;
    w1_cin = 1'b0;
    w1_sub = 1'b0;
    w1_out_ready = 1'b0;
    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
